// File: rtl/mips_program_loader.sv
// mips_program_loader: boot-time loader that sits in front of the single-cycle MIPS core.
// It receives the program image as a byte stream, packs it big-endian into 32-bit words,
// and writes each word to consecutive word-aligned instruction-memory addresses. The core
// is held in reset until the whole image has been written.
//
// Optional feature: define CHECKSUM_EN to expect a trailing 4-byte XOR checksum of the image.
//
// Ports:
//   clk_i          clock, rising edge
//   rst_i          synchronous active-high reset
//   start_i        1-cycle pulse that begins a load; num_words_i is sampled on the same cycle
//   num_words_i    image length in words
//   byte_in_i      stream data
//   byte_valid_i   stream data valid
//   byte_ready_o   loader accepts byte_in_i (transfer = byte_valid_i & byte_ready_o)
//   imem_we_o      instruction-memory write strobe
//   imem_addr_o    instruction-memory byte address (word index * 4)
//   imem_wdata_o   packed instruction word
//   cpu_rst_o      core reset; high until the image is loaded
//   busy_o         load in progress
//   done_o         image loaded, core running
//   err_o          load failed, core held in reset
module mips_program_loader #(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned MAX_WORDS = 256
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [ADDR_W:0]   num_words_i,
    input  logic [7:0]        byte_in_i,
    input  logic              byte_valid_i,
    output logic              byte_ready_o,
    output logic              imem_we_o,
    output logic [31:0]       imem_addr_o,
    output logic [31:0]       imem_wdata_o,
    output logic              cpu_rst_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o
);

    localparam int unsigned CNT_W = ADDR_W + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RECV,
        S_WRITE,
        S_DONE,
`ifdef CHECKSUM_EN
        S_CHECK,
`endif
        S_ERR
    } state_e;

    state_e             state_q;
    logic [CNT_W-1:0]   num_words_q;
    logic [CNT_W-1:0]   word_idx_q;
    logic [1:0]         byte_cnt_q;
    logic [31:0]        buf_q;
    logic               byte_ready_q;
    logic               imem_we_q;
    logic [31:0]        imem_addr_q;
    logic [31:0]        imem_wdata_q;
    logic               cpu_rst_q;
    logic               busy_q;
    logic               done_q;
    logic               err_q;
`ifdef CHECKSUM_EN
    logic [31:0]        xor_q;
`endif

    // Word buffer after shifting in the current byte; the first byte lands in [31:24].
    logic [31:0]        buf_d;
    logic [CNT_W-1:0]   word_idx_d;
    logic               xfer_c;

    always_comb begin
        buf_d      = {buf_q[23:0], byte_in_i};
        word_idx_d = word_idx_q + CNT_W'(1);
        xfer_c     = byte_valid_i & byte_ready_q;
    end

    // Loader FSM with registered outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            num_words_q  <= '0;
            word_idx_q   <= '0;
            byte_cnt_q   <= '0;
            buf_q        <= '0;
            byte_ready_q <= 1'b0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            cpu_rst_q    <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
`ifdef CHECKSUM_EN
            xor_q        <= '0;
`endif
        end else begin
            imem_we_q <= 1'b0;
            case (state_q)
                // Idle, finished and failed states all accept a new load.
                S_IDLE, S_DONE, S_ERR: begin
                    if (start_i) begin
                        done_q      <= 1'b0;
                        err_q       <= 1'b0;
                        cpu_rst_q   <= 1'b1;
                        word_idx_q  <= '0;
                        byte_cnt_q  <= '0;
                        num_words_q <= num_words_i;
`ifdef CHECKSUM_EN
                        xor_q       <= '0;
`endif
                        if (num_words_i > CNT_W'(MAX_WORDS)) begin
                            state_q <= S_ERR;
                            err_q   <= 1'b1;
                        end else if (num_words_i == '0) begin
`ifdef CHECKSUM_EN
                            state_q      <= S_CHECK;
                            byte_ready_q <= 1'b1;
                            busy_q       <= 1'b1;
`else
                            state_q      <= S_DONE;
`endif
                        end else begin
                            state_q      <= S_RECV;
                            byte_ready_q <= 1'b1;
                            busy_q       <= 1'b1;
                        end
                    end else if (state_q == S_DONE) begin
                        // Release the core one cycle after DONE is entered.
                        done_q    <= 1'b1;
                        cpu_rst_q <= 1'b0;
                    end
                end

                S_RECV: begin
                    if (xfer_c) begin
                        buf_q      <= buf_d;
                        byte_cnt_q <= byte_cnt_q + 2'd1;
                        if (byte_cnt_q == 2'd3) begin
                            state_q      <= S_WRITE;
                            byte_ready_q <= 1'b0;
                            imem_we_q    <= 1'b1;
                            imem_addr_q  <= 32'({word_idx_q[ADDR_W-1:0], 2'b00});
                            imem_wdata_q <= buf_d;
`ifdef CHECKSUM_EN
                            xor_q        <= xor_q ^ buf_d;
`endif
                        end
                    end
                end

                S_WRITE: begin
                    word_idx_q <= word_idx_d;
                    if (word_idx_d == num_words_q) begin
`ifdef CHECKSUM_EN
                        state_q      <= S_CHECK;
                        byte_ready_q <= 1'b1;
`else
                        state_q      <= S_DONE;
                        busy_q       <= 1'b0;
`endif
                    end else begin
                        state_q      <= S_RECV;
                        byte_ready_q <= 1'b1;
                    end
                end

`ifdef CHECKSUM_EN
                // Trailing checksum is compared against the XOR of all written words.
                S_CHECK: begin
                    if (xfer_c) begin
                        buf_q      <= buf_d;
                        byte_cnt_q <= byte_cnt_q + 2'd1;
                        if (byte_cnt_q == 2'd3) begin
                            byte_ready_q <= 1'b0;
                            busy_q       <= 1'b0;
                            if (buf_d == xor_q) begin
                                state_q <= S_DONE;
                            end else begin
                                state_q <= S_ERR;
                                err_q   <= 1'b1;
                            end
                        end
                    end
                end
`endif

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign byte_ready_o = byte_ready_q;
    assign imem_we_o    = imem_we_q;
    assign imem_addr_o  = imem_addr_q;
    assign imem_wdata_o = imem_wdata_q;
    assign cpu_rst_o    = cpu_rst_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign err_o        = err_q;

endmodule

// File: tb/tb_mips_program_loader.sv
// Testbench for mips_program_loader: expected writes are computed from the byte image and
// queued; an independent monitor pops and compares each write strobe the DUT issues.
module tb_mips_program_loader;

    localparam int unsigned ADDR_W    = 8;
    localparam int unsigned MAX_WORDS = 256;
    localparam int          MAXI      = int'(MAX_WORDS);
`ifdef CHECKSUM_EN
    localparam bit CS_EN = 1'b1;
`else
    localparam bit CS_EN = 1'b0;
`endif

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              start_i;
    logic [ADDR_W:0]   num_words_i;
    logic [7:0]        byte_in_i;
    logic              byte_valid_i;
    logic              byte_ready_o;
    logic              imem_we_o;
    logic [31:0]       imem_addr_o;
    logic [31:0]       imem_wdata_o;
    logic              cpu_rst_o;
    logic              busy_o;
    logic              done_o;
    logic              err_o;

    always #5 clk_i = ~clk_i;

    mips_program_loader #(
        .ADDR_W    (ADDR_W),
        .MAX_WORDS (MAX_WORDS)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .start_i      (start_i),
        .num_words_i  (num_words_i),
        .byte_in_i    (byte_in_i),
        .byte_valid_i (byte_valid_i),
        .byte_ready_o (byte_ready_o),
        .imem_we_o    (imem_we_o),
        .imem_addr_o  (imem_addr_o),
        .imem_wdata_o (imem_wdata_o),
        .cpu_rst_o    (cpu_rst_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .err_o        (err_o)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t         exp_q [$];
    logic [7:0]  img [$];
    logic [7:0]  case1_img [8] = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h20, 8'h09, 8'h00, 8'h07};
    int          checks   = 0;
    int          failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every write strobe must match the oldest expected write.
    initial begin
        wr_t e;
        forever begin
            @(posedge clk_i);
            #1;
            if (imem_we_o === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_write: addr 0x%08h data 0x%08h at %0t",
                             imem_addr_o, imem_wdata_o, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("write_addr", imem_addr_o, e.addr);
                    check("write_data", imem_wdata_o, e.data);
                    check("cpu_rst_during_write", 32'(cpu_rst_o), 32'd1);
                end
            end
        end
    end

    function automatic int gap_for(input int mode);
        if (mode == 0) return 0;
        if (mode == 1) return 1;
        return int'($urandom_range(0, 3));
    endfunction

    // Present one byte after 'gap' idle cycles and hold it until accepted.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        repeat (gap) @(negedge clk_i);
        byte_valid_i = 1'b1;
        byte_in_i    = b;
        t = 0;
        while (byte_ready_o !== 1'b1 && t < 100) begin
            @(negedge clk_i);
            t++;
        end
        check("byte_accepted", 32'(byte_ready_o), 32'd1);
        @(negedge clk_i);
        byte_valid_i = 1'b0;
    endtask

    task automatic pulse_start(input int n);
        @(negedge clk_i);
        start_i     = 1'b1;
        num_words_i = (ADDR_W + 1)'(n);
        @(negedge clk_i);
        start_i     = 1'b0;
    endtask

    // One complete load: build the reference, drive the stream, check the outcome.
    task automatic run_load(input int n, input int gap_mode, input bit use_img,
                            input bit bad_cs, input bit inject_start);
        logic [31:0] w;
        logic [31:0] x;
        logic [31:0] cs;
        bit          exp_done;
        int          t;
        if (!use_img) begin
            img.delete();
            if (n <= MAXI) for (int i = 0; i < 4 * n; i++) img.push_back(8'($urandom));
        end
        x = '0;
        if (n <= MAXI) begin
            for (int i = 0; i < n; i++) begin
                w = {img[4*i], img[4*i+1], img[4*i+2], img[4*i+3]};
                exp_q.push_back('{addr: 32'(i * 4), data: w});
                x = x ^ w;
            end
        end
        exp_done = (n <= MAXI) && !(CS_EN && bad_cs);

        pulse_start(n);
        if (n <= MAXI && (n != 0 || CS_EN)) begin
            check("busy_after_start", 32'(busy_o), 32'd1);
            check("cpu_rst_after_start", 32'(cpu_rst_o), 32'd1);
        end
        if (n == 0 && !CS_EN) begin
            check("zero_len_done_cycle1", 32'(done_o), 32'd0);
            @(negedge clk_i);
            check("zero_len_done_cycle2", 32'(done_o), 32'd1);
        end
        if (n <= MAXI) begin
            for (int i = 0; i < 4 * n; i++) begin
                send_byte(img[i], gap_for(gap_mode));
                if (inject_start && i == 0) begin
                    start_i     = 1'b1;
                    num_words_i = (ADDR_W + 1)'(3);
                    @(negedge clk_i);
                    start_i     = 1'b0;
                end
            end
            if (CS_EN) begin
                cs = x ^ 32'(bad_cs);
                send_byte(cs[31:24], gap_for(gap_mode));
                send_byte(cs[23:16], gap_for(gap_mode));
                send_byte(cs[15:8],  gap_for(gap_mode));
                send_byte(cs[7:0],   gap_for(gap_mode));
            end
        end
        t = 0;
        while (!(done_o === 1'b1 || err_o === 1'b1) && t < 200) begin
            @(negedge clk_i);
            t++;
        end
        check("load_finished", 32'(done_o | err_o), 32'd1);
        check("done", 32'(done_o), 32'(exp_done));
        check("err", 32'(err_o), 32'(!exp_done));
        check("cpu_rst_end", 32'(cpu_rst_o), 32'(!exp_done));
        check("busy_end", 32'(busy_o), 32'd0);
        repeat (3) @(negedge clk_i);
        check("writes_drained", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        rst_i        = 1'b1;
        start_i      = 1'b0;
        num_words_i  = '0;
        byte_in_i    = '0;
        byte_valid_i = 1'b0;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        check("reset_cpu_rst", 32'(cpu_rst_o), 32'd1);
        check("reset_busy", 32'(busy_o), 32'd0);
        check("reset_done", 32'(done_o), 32'd0);
        check("reset_err", 32'(err_o), 32'd0);
        check("reset_we", 32'(imem_we_o), 32'd0);
        check("reset_ready", 32'(byte_ready_o), 32'd0);

        // Directed two-word image, back-to-back and with valid toggling.
        img.delete();
        for (int i = 0; i < 8; i++) img.push_back(case1_img[i]);
        run_load(2, 0, 1'b1, 1'b0, 1'b0);
        run_load(2, 1, 1'b1, 1'b0, 1'b0);
        if (CS_EN) run_load(2, 0, 1'b1, 1'b1, 1'b0);

        // Zero-length image.
        run_load(0, 0, 1'b0, 1'b0, 1'b0);

        // Length overflow, then recovery with a valid load.
        run_load(MAXI + 1, 0, 1'b0, 1'b0, 1'b0);
        run_load(3, 2, 1'b0, 1'b0, 1'b0);

        // Reset in the middle of a word: nothing may be written for the aborted load.
        pulse_start(2);
        send_byte(8'hAA, 0);
        send_byte(8'hBB, 0);
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        check("midrst_cpu_rst", 32'(cpu_rst_o), 32'd1);
        check("midrst_busy", 32'(busy_o), 32'd0);
        check("midrst_ready", 32'(byte_ready_o), 32'd0);
        repeat (3) @(negedge clk_i);
        check("midrst_no_write", 32'(exp_q.size()), 32'd0);
        run_load(1, 0, 1'b0, 1'b0, 1'b1);

        // Largest accepted image.
        run_load(MAXI, 0, 1'b0, 1'b0, 1'b0);

        // Randomized images and gaps.
        for (int k = 0; k < 12; k++) begin
            run_load(int'($urandom_range(1, 6)), 2, 1'b0,
                     CS_EN && ($urandom_range(0, 1) == 1), 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
